apb_mem_slave: RTL and testbench
================================

// Module: apb_mem_slave
// PURPOSE
//  Parametrised APB4 memory-backed slave: word-addressed register file with byte strobes,
//  programmable wait states (PREADY) and error response (PSLVERR). Drop-in peripheral
//  behind the APB interconnect; next generation of the fixed 8b-addr/32b-data/64-word slave.
// PARAMETERS
//  ADDR_W       8   paddr width (byte address)
//  DATA_W       32  data width; 8, 16, 32 or 64
//  DEPTH        64  number of DATA_W words; must satisfy DEPTH*DATA_W/8 <= 2**ADDR_W
//  WAIT_STATES  0   extra access-phase cycles with pready=0 before completion (0..15)
// PORTS
//  clk      in   1         clock, all logic on rising edge
//  rst      in   1         asynchronous, active-high reset
//  paddr    in   ADDR_W    byte address; word index idx = paddr[ADDR_W-1:log2(DATA_W/8)]
//  psel     in   1         slave select
//  penable  in   1         access phase
//  pwrite   in   1         1=write, 0=read
//  pwdata   in   DATA_W    write data
//  pstrb    in   DATA_W/8  byte-lane write strobes (ignored on reads)
//  pready   out  1         transfer completes this cycle
//  prdata   out  DATA_W    read data, valid when pready & !pwrite
//  pslverr  out  1         error response, valid only when pready=1
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, cnt=0, prdata=0, pready=0, pslverr=0, all mem words=0.
//  FSM states IDLE, ACCESS.
//  IDLE: on psel & !penable (setup) -> capture idx, pwrite, pwdata, pstrb into *_q;
//    cnt<=WAIT_STATES; err_q<=(idx>=DEPTH); go ACCESS. penable=1 in IDLE is ignored.
//  ACCESS: pready = (cnt==0) (decoded from registered state/cnt, no comb path from inputs).
//    cnt!=0: cnt<=cnt-1, stay ACCESS.
//    cnt==0 & psel & penable: transfer completes on this edge -> go IDLE.
//      write, !err_q: mem[idx_q] byte lane b <= pwdata_q lane b where pstrb_q[b]=1.
//      pstrb_q=0 is a legal no-op write, pslverr=0.
//    psel=0 in ACCESS (master abort): go IDLE, no write, prdata unchanged.
//  prdata: loaded on the edge entering the cycle where pready=1 (setup edge if WAIT_STATES=0,
//    else the edge where cnt goes 1->0) with mem[idx_q] for reads, 0 when err_q;
//    held otherwise (not cleared between transfers). Writes never modify prdata.
//  pslverr = pready & err_q; an errored write leaves memory untouched.
//  Latency: setup cycle + (WAIT_STATES+1) access cycles; back-to-back setup accepted in the
//    cycle after pready=1 (zero idle cycles).
//  Read-after-write to same idx in next transfer returns the new data.
//  Inputs sampled only at setup; changes in paddr/pwdata during ACCESS are ignored.
//  Reset mid-transfer: immediate return to IDLE, pready=0, pending write discarded,
//    memory cleared.
// TESTING
//  1 WAIT_STATES=0: write 0xDEADBEEF @0x04, pstrb=4'hF; read @0x04 -> pready in 2nd cycle,
//    prdata=0xDEADBEEF, pslverr=0.
//  2 Strobes: write 0x11223344 @0x08 all lanes, then 0xAABBCCDD pstrb=4'b0101
//    -> read 0x11BB33DD.
//  3 WAIT_STATES=2: read -> pready low for 2 access cycles, high on 3rd, prdata valid
//    only then; back-to-back write accepted next cycle.
//  4 DEPTH=16, ADDR_W=8: write @0x40 (idx 16) -> pslverr=1 with pready, no mem change;
//    read @0x40 -> prdata=0, pslverr=1.
//  5 WAIT_STATES=3: drop psel after 1 access cycle of a write -> FSM IDLE, target word
//    unchanged, next transfer normal.
//  6 Assert rst during ACCESS of a write 0x12345678 @0x0C -> pready=0 immediately;
//    read @0x0C after release -> 0x00000000.

Source files
------------

// File: rtl/apb_mem_if.sv
// APB4 bus bundle between an APB master and a memory-backed slave.
// Handshake: the master holds psel=1/penable=0 for one setup cycle, then raises penable and holds
// both until the slave returns pready=1; prdata/pslverr are valid only in that pready=1 cycle.
interface apb_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic                pready;
    logic [DATA_W-1:0]   prdata;
    logic                pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB4 slave backed by a DEPTH x DATA_W word memory with byte strobes, fixed wait states
// and an error response for out-of-range word indices.
module apb_mem_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic     clk,
    input  logic     rst,
    apb_mem_if.slave bus,
    output logic     dbg_access
);
    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [MEM_AW-1:0]   idx_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       strb_q;
    logic                err_q;
    logic [DATA_W-1:0]   prdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]    idx_in;
    logic [MEM_AW-1:0]   midx_in;
    logic                err_in;
    logic                setup;
    logic                unused_addr;

    assign idx_in  = bus.paddr[ADDR_W-1:OFF_W];
    assign midx_in = idx_in[MEM_AW-1:0];
    assign err_in  = ({1'b0, idx_in} >= DEPTH_L);
    assign setup   = bus.psel & ~bus.penable;
    // Byte-offset bits are parity-reduced only to mark them as intentionally unused.
    assign unused_addr = ^bus.paddr;

    // Outputs decode registered state only, so there is no combinational path from the bus.
    assign bus.pready  = (state == ACCESS) && (cnt == 4'd0);
    assign bus.pslverr = bus.pready & err_q;
    assign bus.prdata  = prdata_q;
    assign dbg_access  = (state == ACCESS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            err_q    <= 1'b0;
            prdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        idx_q   <= midx_in;
                        write_q <= bus.pwrite;
                        wdata_q <= bus.pwdata;
                        strb_q  <= bus.pstrb;
                        err_q   <= err_in;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= ACCESS;
                        // With no wait states the read data must be ready in the first access cycle.
                        if (WAIT_STATES == 0 && !bus.pwrite)
                            prdata_q <= err_in ? '0 : mem[midx_in];
                    end
                end
                ACCESS: begin
                    if (!bus.psel) begin
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1 && !write_q)
                            prdata_q <= err_q ? '0 : mem[idx_q];
                    end else if (bus.penable) begin
                        state <= IDLE;
                        if (write_q && !err_q) begin
                            for (int b = 0; b < NB; b++)
                                if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three instances (0/2/3 wait states, one with DEPTH=16)
// share one driven bus; a behavioural model is compared against every instance each cycle.
module tb_apb_mem_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  paddr   = '0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] pwdata  = '0;
    logic [3:0]  pstrb   = '0;
    int          sel_id  = 0;

    apb_mem_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();
    apb_mem_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();
    apb_mem_if #(.ADDR_W(8), .DATA_W(32)) bus2 ();
    logic dbg0, dbg1, dbg2;

    assign bus0.paddr = paddr;  assign bus0.penable = penable; assign bus0.pwrite = pwrite;
    assign bus0.pwdata = pwdata; assign bus0.pstrb = pstrb;    assign bus0.psel = psel && (sel_id == 0);
    assign bus1.paddr = paddr;  assign bus1.penable = penable; assign bus1.pwrite = pwrite;
    assign bus1.pwdata = pwdata; assign bus1.pstrb = pstrb;    assign bus1.psel = psel && (sel_id == 1);
    assign bus2.paddr = paddr;  assign bus2.penable = penable; assign bus2.pwrite = pwrite;
    assign bus2.pwdata = pwdata; assign bus2.pstrb = pstrb;    assign bus2.psel = psel && (sel_id == 2);

    apb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .dbg_access(dbg0));
    apb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .dbg_access(dbg1));
    apb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .bus(bus2.slave), .dbg_access(dbg2));

    logic        act_pready [3];
    logic        act_pslverr [3];
    logic        act_dbg [3];
    logic [31:0] act_prdata [3];
    always_comb begin
        act_pready[0] = bus0.pready; act_pslverr[0] = bus0.pslverr; act_prdata[0] = bus0.prdata; act_dbg[0] = dbg0;
        act_pready[1] = bus1.pready; act_pslverr[1] = bus1.pslverr; act_prdata[1] = bus1.prdata; act_dbg[1] = dbg1;
        act_pready[2] = bus2.pready; act_pslverr[2] = bus2.pslverr; act_prdata[2] = bus2.prdata; act_dbg[2] = dbg2;
    end

    // Model: per-instance memory image and the outputs each slave must show this cycle.
    int          ws_of [3]    = '{0, 2, 3};
    int          depth_of [3] = '{64, 16, 64};
    logic [31:0] mdl_mem [3][64];
    logic        exp_pready [3];
    logic        exp_pslverr [3];
    logic [31:0] exp_prdata [3];
    logic [31:0] exp_q [$];
    logic        chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 64; w++) mdl_mem[i][w] = '0;
            exp_pready[i]  = 1'b0;
            exp_pslverr[i] = 1'b0;
            exp_prdata[i]  = '0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("pready[%0d]", i), 32'(act_pready[i]), 32'(exp_pready[i]));
                check($sformatf("pslverr[%0d]", i), 32'(act_pslverr[i]), 32'(exp_pslverr[i]));
                check($sformatf("prdata[%0d]", i), act_prdata[i], exp_prdata[i]);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the completing edge, ready for back-to-back use.
    task automatic xfer(input int id, input bit wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rd, output logic err);
        int idx;
        bit e;
        idx = int'(addr[7:2]);
        e   = (idx >= depth_of[id]);
        sel_id = id; psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr = addr ^ 8'h04; pwdata = ~data; pstrb = ~strb;
        for (int k = 0; k <= ws_of[id]; k++) begin
            if (k == ws_of[id]) begin
                exp_pready[id]  = 1'b1;
                exp_pslverr[id] = e;
                if (!wr) exp_prdata[id] = e ? 32'h0 : mdl_mem[id][idx];
            end
            @(negedge clk);
            rd  = act_prdata[id];
            err = act_pslverr[id];
            @(posedge clk); #1;
        end
        if (wr && !e) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl_mem[id][idx][8*b +: 8] = data[8*b +: 8];
        end
        exp_pready[id] = 1'b0; exp_pslverr[id] = 1'b0;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input int id, input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] rd;
        logic err;
        xfer(id, 1'b1, addr, data, strb, rd, err);
    endtask

    task automatic rd_expect(input string name, input int id, input logic [7:0] addr,
                             input logic [31:0] lit, input logic lit_err);
        logic [31:0] rd;
        logic err;
        exp_q.push_back(lit);
        xfer(id, 1'b0, addr, 32'h0, 4'h0, rd, err);
        check(name, rd, exp_q.pop_front());
        check({name, "_err"}, 32'(err), 32'(lit_err));
    endtask

    task automatic abort_write(input int id, input logic [7:0] addr, input logic [31:0] data);
        sel_id = id; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = addr; pwdata = data; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic err;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_pready[%0d]", i), 32'(act_pready[i]), 32'h0);
            check($sformatf("rst_prdata[%0d]", i), act_prdata[i], 32'h0);
            check($sformatf("rst_state[%0d]", i), 32'(act_dbg[i]), 32'h0);
        end
        rst = 1'b0;
        chk_en = 1'b1;

        // 0 wait states: write then read back
        wr(0, 8'h04, 32'hDEADBEEF, 4'hF);
        rd_expect("t1_rd04", 0, 8'h04, 32'hDEADBEEF, 1'b0);

        // byte strobes, then a no-op strobe-free write
        wr(0, 8'h08, 32'h11223344, 4'hF);
        wr(0, 8'h08, 32'hAABBCCDD, 4'b0101);
        rd_expect("t2_strb", 0, 8'h08, 32'h11BB33DD, 1'b0);
        xfer(0, 1'b1, 8'h08, 32'hFFFFFFFF, 4'h0, rd, err);
        check("t2_nostrb_err", 32'(err), 32'h0);
        rd_expect("t2_nostrb", 0, 8'h08, 32'h11BB33DD, 1'b0);

        // 2 wait states, back-to-back, last valid index and out-of-range index
        rd_expect("t3_rd_init", 1, 8'h10, 32'h0, 1'b0);
        wr(1, 8'h10, 32'hCAFEF00D, 4'hF);
        rd_expect("t3_rd10", 1, 8'h10, 32'hCAFEF00D, 1'b0);
        wr(1, 8'h3C, 32'h0BADC0DE, 4'hF);
        wr(1, 8'h00, 32'hA5A5A5A5, 4'hF);
        xfer(1, 1'b1, 8'h40, 32'h5A5A5A5A, 4'hF, rd, err);
        check("t4_wr_err", 32'(err), 32'h1);
        rd_expect("t4_rd3c", 1, 8'h3C, 32'h0BADC0DE, 1'b0);
        rd_expect("t4_rd_err", 1, 8'h40, 32'h0, 1'b1);
        rd_expect("t4_rd00", 1, 8'h00, 32'hA5A5A5A5, 1'b0);

        // 3 wait states: master abort leaves the word untouched
        wr(2, 8'h14, 32'h00000055, 4'hF);
        abort_write(2, 8'h14, 32'hFFFFFFFF);
        check("t5_state_idle", 32'(act_dbg[2]), 32'h0);
        rd_expect("t5_rd14", 2, 8'h14, 32'h00000055, 1'b0);
        wr(2, 8'h18, 32'h87654321, 4'b1100);
        rd_expect("t5_rd18", 2, 8'h18, 32'h87650000, 1'b0);

        // reset in the middle of a completing write
        sel_id = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h0C; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        check("t6_pready_before", 32'(act_pready[0]), 32'h1);
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_pready_async", 32'(act_pready[0]), 32'h0);
        check("t6_state_async", 32'(act_dbg[0]), 32'h0);
        mdl_reset();
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        rd_expect("t6_rd0c", 0, 8'h0C, 32'h0, 1'b0);
        rd_expect("t6_rd04", 0, 8'h04, 32'h0, 1'b0);
        rd_expect("t6_rd14", 2, 8'h14, 32'h0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
